// File: rtl/spart_fifo_if.sv
// spart_fifo processor-side bus bundle.
// Chip select, direction, address and the two ready flags.
interface spart_fifo_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs, iorw, ioaddr,
    input  rda, tbr
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output rda, tbr
  );
endinterface

// File: rtl/spart_fifo.sv
// spart_fifo: buffered programmable-baud serial transceiver.
// Optional even parity in both directions: define SPART_PARITY_EN.
module spart_fifo #(
  parameter int          DATA_W      = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          STOP_BITS   = 1,
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic        clk,
  input  logic        rst,
  spart_fifo_if.slave bus,
  inout  wire  [7:0]  databus,
  output logic        txd,
  input  logic        rxd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST = 4'(DATA_W - 1);

  logic       rd, wr;
  logic [7:0] wdata, rdata;
  logic       status_rd;
  assign rd        = bus.iocs & bus.iorw;
  assign wr        = bus.iocs & ~bus.iorw;
  assign wdata     = databus;
  assign status_rd = rd && bus.ioaddr == 2'b01;
  assign databus   = rd ? rdata : 8'bz;

  logic [15:0] div, per, per_m1, half, half_m1;
  assign per     = (div == 16'd0) ? 16'd1 : div;
  assign per_m1  = per - 16'd1;
  assign half    = {1'b0, per[15:1]};
  assign half_m1 = (half == 16'd0) ? 16'd0 : half - 16'd1;

  // Divisor register, byte-writable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div <= DEFAULT_DIV;
    else if (wr && bus.ioaddr == 2'b10) div[7:0] <= wdata;
    else if (wr && bus.ioaddr == 2'b11) div[15:8] <= wdata;
  end

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]       tx_wp, tx_rp;
  logic              tx_empty, tx_full, tx_push, tx_pop;
  logic [DATA_W-1:0] tx_head;
  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];
  assign tx_push  = wr && bus.ioaddr == 2'b00 && (!tx_full || tx_pop);

  // TX FIFO storage.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= wdata[DATA_W-1:0];
  end

  // TX FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef SPART_PARITY_EN
    TX_PAR,
`endif
    TX_STOP
  } tx_state_t;

  tx_state_t         tx_state;
  logic [15:0]       tx_cnt;
  logic [3:0]        tx_idx;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_sidx, tx_bnd, tx_last, tx_busy;
`ifdef SPART_PARITY_EN
  logic              tx_par;
`endif
  assign tx_bnd  = tx_cnt == 16'd0;
  assign tx_last = (STOP_BITS == 1) || tx_sidx;
  assign tx_busy = tx_state != TX_IDLE;
  assign tx_pop  = !tx_empty && (tx_state == TX_IDLE ||
                   (tx_state == TX_STOP && tx_bnd && tx_last));

  // Transmit FSM; txd is registered, bit timer reloads at each boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_sidx  <= 1'b0;
      txd      <= 1'b1;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= tx_head;
            txd      <= 1'b0;
            tx_cnt   <= per_m1;
            tx_state <= TX_START;
`ifdef SPART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
          end
        end
        TX_START: begin
          if (tx_bnd) begin
            txd      <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
            tx_idx   <= '0;
            tx_cnt   <= per_m1;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (tx_bnd) begin
            tx_cnt <= per_m1;
            if (tx_idx == LAST) begin
`ifdef SPART_PARITY_EN
              txd      <= tx_par;
              tx_state <= TX_PAR;
`else
              txd      <= 1'b1;
              tx_sidx  <= 1'b0;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_idx <= tx_idx + 4'd1;
              txd    <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
`ifdef SPART_PARITY_EN
        TX_PAR: begin
          if (tx_bnd) begin
            txd      <= 1'b1;
            tx_sidx  <= 1'b0;
            tx_cnt   <= per_m1;
            tx_state <= TX_STOP;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
`endif
        TX_STOP: begin
          if (!tx_bnd) tx_cnt <= tx_cnt - 16'd1;
          else if (!tx_last) begin
            tx_sidx <= 1'b1;
            tx_cnt  <= per_m1;
          end else if (tx_pop) begin
            tx_sh    <= tx_head;
            txd      <= 1'b0;
            tx_cnt   <= per_m1;
            tx_state <= TX_START;
`ifdef SPART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
          end else tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic s1, s2, s3;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]       rx_wp, rx_rp;
  logic              rx_empty, rx_full, rx_push, rx_pop;
  logic [DATA_W-1:0] rx_head;
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];
  assign rx_pop   = rd && bus.ioaddr == 2'b00 && !rx_empty;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef SPART_PARITY_EN
    RX_PAR,
`endif
    RX_STOP, RX_WAIT
  } rx_state_t;

  rx_state_t         rx_state;
  logic [15:0]       rx_cnt;
  logic [3:0]        rx_idx;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_bnd, rx_good, rx_bad;
  logic              ovr_set, perr_set;
`ifdef SPART_PARITY_EN
  logic              rx_par, rx_pbad;
  assign perr_set = rx_good && rx_pbad;
`else
  assign perr_set = 1'b0;
`endif
  assign rx_bnd  = rx_cnt == 16'd0;
  assign rx_good = rx_state == RX_STOP && rx_bnd && s2;
  assign rx_bad  = rx_state == RX_STOP && rx_bnd && !s2;
  assign rx_push = rx_good && (!rx_full || rx_pop);
  assign ovr_set = rx_good && rx_full && !rx_pop;

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
  end

  // RX FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // Receive FSM; mid-bit sampling from the detected falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
`ifdef SPART_PARITY_EN
      rx_par   <= 1'b0;
      rx_pbad  <= 1'b0;
`endif
    end else begin
      unique case (rx_state)
        RX_IDLE: begin
          if (s3 && !s2) begin
            rx_cnt   <= half_m1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (!rx_bnd) rx_cnt <= rx_cnt - 16'd1;
          else if (s2) rx_state <= RX_IDLE;
          else begin
            rx_idx   <= '0;
            rx_cnt   <= per_m1;
            rx_state <= RX_DATA;
`ifdef SPART_PARITY_EN
            rx_par   <= 1'b0;
`endif
          end
        end
        RX_DATA: begin
          if (rx_bnd) begin
            rx_sh  <= {s2, rx_sh[DATA_W-1:1]};
            rx_cnt <= per_m1;
`ifdef SPART_PARITY_EN
            rx_par <= rx_par ^ s2;
            if (rx_idx == LAST) rx_state <= RX_PAR;
`else
            if (rx_idx == LAST) rx_state <= RX_STOP;
`endif
            else rx_idx <= rx_idx + 4'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
`ifdef SPART_PARITY_EN
        RX_PAR: begin
          if (rx_bnd) begin
            rx_pbad  <= rx_par ^ s2;
            rx_cnt   <= per_m1;
            rx_state <= RX_STOP;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
`endif
        RX_STOP: begin
          if (!rx_bnd) rx_cnt <= rx_cnt - 16'd1;
          else if (s2) rx_state <= RX_IDLE;
          else rx_state <= RX_WAIT;
        end
        RX_WAIT: begin
          if (s2) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic ovr, ferr, perr;

  // Sticky error flags; a same-cycle new error beats the read-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~status_rd);
      ferr <= rx_bad   | (ferr & ~status_rd);
      perr <= perr_set | (perr & ~status_rd);
    end
  end

  logic rda, tbr;
  assign rda     = !rx_empty;
  assign tbr     = !tx_full;
  assign bus.rda = rda;
  assign bus.tbr = tbr;

  // Read mux, combinational from the current address.
  always_comb begin
    rdata = 8'h00;
    unique case (bus.ioaddr)
      2'b00: rdata = rx_empty ? 8'h00 : 8'(rx_head);
      2'b01: rdata = {2'b00, tx_busy, perr, ferr, ovr, tbr, rda};
      2'b10: rdata = div[7:0];
      2'b11: rdata = div[15:8];
    endcase
  end
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: scenario tasks for spart_fifo.
// Bytes sent are queued and checked as they are read back.
module tb_spart_fifo;
`ifdef SPART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spart_fifo_if bus();
  wire  [7:0] databus;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  assign databus = drv_en ? drv_data : 8'bz;

  logic txd, rxd;
  logic rxd_drv = 1'b1;
  logic loop = 1'b0;
  assign rxd = loop ? txd : rxd_drv;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  spart_fifo dut (
    .clk(clk), .rst(rst), .bus(bus),
    .databus(databus), .txd(txd), .rxd(rxd)
  );

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b0; bus.ioaddr = a;
    drv_data = d; drv_en = 1'b1;
    @(posedge clk); #1;
    bus.iocs = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = a;
    #2 d = databus;
    @(posedge clk); #1;
    bus.iocs = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (bus.tbr !== 1'b1 && n < 400) begin
      @(negedge clk); n++;
    end
    tests++;
    if (bus.tbr !== 1'b1) begin
      fails++;
      $display("FAIL tbr_wait: got %b want 1", bus.tbr);
    end
    bus_write(2'b00, d);
  endtask

  task automatic drive_bit(input logic v, input int p);
    rxd_drv = v;
    repeat (p) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic pflip,
                             input logic stop, input int p);
    @(negedge clk);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
`ifdef SPART_PARITY_EN
    drive_bit((^d) ^ pflip, p);
`endif
    drive_bit(stop, p);
    rxd_drv = 1'b1;
  endtask

  task automatic read_expect(input string nm);
    logic [7:0] v, e;
    bus_read(2'b00, v);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s: got %h want <queue empty>", nm, v);
    end else begin
      e = sb.pop_front();
      if (v !== e) begin
        fails++;
        $display("FAIL %s: got %h want %h", nm, v, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL rst_txd: got %b want 1", txd);
    end
    tests++;
    if (bus.rda !== 1'b0) begin
      fails++; $display("FAIL rst_rda: got %b want 0", bus.rda);
    end
    tests++;
    if (bus.tbr !== 1'b1) begin
      fails++; $display("FAIL rst_tbr: got %b want 1", bus.tbr);
    end
    rst = 1'b1;
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h02) begin
      fails++; $display("FAIL rst_status: got %h want 02", v);
    end
    bus_read(2'b10, v);
    tests++;
    if (v !== 8'h45) begin
      fails++; $display("FAIL rst_div_lo: got %h want 45", v);
    end
    bus_read(2'b11, v);
    tests++;
    if (v !== 8'h01) begin
      fails++; $display("FAIL rst_div_hi: got %h want 01", v);
    end
    @(negedge clk);
    bus.iocs = 1'b0; bus.iorw = 1'b1; bus.ioaddr = 2'b01;
    drv_data = 8'hA5; drv_en = 1'b1;
    #2 v = databus;
    drv_en = 1'b0;
    tests++;
    if (v !== 8'hA5) begin
      fails++; $display("FAIL bus_hiz: got %h want a5", v);
    end
  endtask

  task automatic test_tx_frame();
    logic [7:0] d;
    logic       bits [12];
    logic       seen;
    int         bad;
    d = 8'hA5;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    bits[9] = ^d;
    bits[NB - 1] = 1'b1;
    bus_write(2'b10, 8'd4);
    bus_write(2'b11, 8'd0);
    bus_write(2'b00, d);
    bus.iocs = 1'b1; bus.iorw = 1'b1; bus.ioaddr = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (txd === 1'b0) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL tx_start_seen: got 0 want 1");
    end else begin
      for (int b = 0; b < NB; b++) begin
        bad = 0;
        for (int k = 0; k < 4; k++) begin
          if (b > 0 || k > 0) @(negedge clk);
          if (txd !== bits[b]) bad++;
        end
        tests++;
        if (bad != 0) begin
          fails++;
          $display("FAIL tx_bit%0d: got %0d bad samples want 0 (level %b)",
                   b, bad, bits[b]);
        end
      end
      tests++;
      if (databus[5] !== 1'b1) begin
        fails++; $display("FAIL tx_busy_stop: got %b want 1", databus[5]);
      end
      @(negedge clk);
      tests++;
      if (databus[5] !== 1'b0) begin
        fails++; $display("FAIL tx_busy_after: got %b want 0", databus[5]);
      end
      tests++;
      if (txd !== 1'b1) begin
        fails++; $display("FAIL tx_idle_high: got %b want 1", txd);
      end
    end
    bus.iocs = 1'b0;
  endtask

  task automatic test_loopback();
    logic [7:0] vals [4];
    vals = '{8'h3C, 8'hC3, 8'h00, 8'hFF};
    loop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_tx(vals[i]);
      sb.push_back(vals[i]);
    end
    repeat (4 * NB * 4 + 40) @(negedge clk);
    tests++;
    if (bus.rda !== 1'b1) begin
      fails++; $display("FAIL loop_rda: got %b want 1", bus.rda);
    end
    for (int i = 0; i < 4; i++) read_expect("loop_data");
    tests++;
    if (bus.rda !== 1'b0) begin
      fails++; $display("FAIL loop_rda_empty: got %b want 0", bus.rda);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    loop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_tx(vals[i]);
      if (i < 4) sb.push_back(vals[i]);
    end
    repeat (5 * NB * 4 + 60) @(negedge clk);
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h07) begin
      fails++; $display("FAIL ovr_status: got %h want 07", v);
    end
    for (int i = 0; i < 4; i++) read_expect("ovr_data");
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h02) begin
      fails++; $display("FAIL ovr_cleared: got %h want 02", v);
    end
    loop = 1'b0;
  endtask

  task automatic test_false_start();
    logic [7:0] v;
    loop = 1'b0;
    rxd_drv = 1'b1;
    bus_write(2'b10, 8'd8);
    @(negedge clk); rxd_drv = 1'b0;
    @(negedge clk); rxd_drv = 1'b1;
    repeat (40) @(negedge clk);
    tests++;
    if (bus.rda !== 1'b0) begin
      fails++; $display("FAIL false_rda: got %b want 0", bus.rda);
    end
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h02) begin
      fails++; $display("FAIL false_status: got %h want 02", v);
    end
  endtask

  task automatic test_framing();
    logic [7:0] v;
    drive_frame(8'h55, 1'b0, 1'b0, 8);
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (bus.rda !== 1'b0) begin
      fails++; $display("FAIL frame_rda: got %b want 0", bus.rda);
    end
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h0A) begin
      fails++; $display("FAIL frame_status: got %h want 0a", v);
    end
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h02) begin
      fails++; $display("FAIL frame_cleared: got %h want 02", v);
    end
  endtask

  task automatic test_good_rx();
    logic [7:0] v;
    drive_frame(8'h96, 1'b0, 1'b1, 8);
    sb.push_back(8'h96);
    repeat (20) @(negedge clk);
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h03) begin
      fails++; $display("FAIL rx_good_status: got %h want 03", v);
    end
    read_expect("rx_good_data");
  endtask

`ifdef SPART_PARITY_EN
  task automatic test_parity();
    logic [7:0] v;
    drive_frame(8'h01, 1'b1, 1'b1, 8);
    sb.push_back(8'h01);
    repeat (20) @(negedge clk);
    bus_read(2'b01, v);
    tests++;
    if (v !== 8'h13) begin
      fails++; $display("FAIL parity_status: got %h want 13", v);
    end
    read_expect("parity_data");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.iocs = 1'b0;
    bus.iorw = 1'b0;
    bus.ioaddr = 2'b00;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_false_start();
    test_framing();
    test_good_rx();
`ifdef SPART_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
